// File: rtl/trace_decoder.sv
// Traceback coordinate stream to aligned character pairs with edit ops and path checking.
// Define ALN_STATS_EN to build the match/mismatch/indel counters and the recomputed score.
module trace_decoder #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int SWIDTH      = 16,
    parameter int MATCH       = 1,
    parameter int INDEL       = -1,
    parameter int MISMATCH    = -1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*CORD_LENGTH-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CWIDTH-1:0]          out_c1,
    output logic [CWIDTH-1:0]          out_c2,
    output logic [1:0]                 out_op,
    output logic                       out_last,
    output logic                       done,
    output logic                       err,
    output logic [CORD_LENGTH:0]       n_match,
    output logic [CORD_LENGTH:0]       n_mismatch,
    output logic [CORD_LENGTH:0]       n_indel,
    output logic signed [SWIDTH-1:0]   score
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRACK, S_LAST, S_FIN, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_MATCH    = 2'b00,
        OP_MISMATCH = 2'b01,
        OP_GAP_S2   = 2'b10,
        OP_GAP_S1   = 2'b11
    } op_t;

    localparam logic [CORD_LENGTH-1:0] TOP_IDX = CORD_LENGTH'(LENGTH - 1);

    state_t                 state, state_n;
    logic                   rdy_q;
    logic [CORD_LENGTH-1:0] cx, cy;
    logic [CORD_LENGTH-1:0] nx, ny;
    logic                   accept, fire, out_free;
    logic                   step_x, step_y, hold_x, hold_y;
    logic                   diag, up, left, legal;
    logic                   is_start, is_origin;
    logic                   load;
    logic [CWIDTH-1:0]      c1_cur, c2_cur;
    logic [CWIDTH-1:0]      ent_c1, ent_c2;
    op_t                    ent_op, op_q;
    logic                   ent_last;

    function automatic logic [CWIDTH-1:0] pick(input logic [LENGTH*CWIDTH-1:0] str,
                                              input logic [CORD_LENGTH-1:0]   idx);
        logic [CWIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < LENGTH; j++)
            if (idx == CORD_LENGTH'(j)) r = str[j*CWIDTH +: CWIDTH];
        return r;
    endfunction

    assign nx = in_data[CORD_LENGTH-1:0];
    assign ny = in_data[2*CORD_LENGTH-1:CORD_LENGTH];

    assign out_free = !out_valid || out_ready;
    assign fire     = out_valid && out_ready;
    assign in_ready = rdy_q && out_free;
    assign accept   = in_valid && in_ready;

    // Widened compare so a wrap from 0 to all-ones never passes as a step of one.
    assign step_x = ({1'b0, nx} + (CORD_LENGTH+1)'(1)) == {1'b0, cx};
    assign step_y = ({1'b0, ny} + (CORD_LENGTH+1)'(1)) == {1'b0, cy};
    assign hold_x = (nx == cx);
    assign hold_y = (ny == cy);
    assign diag   = step_x && step_y;
    assign up     = hold_x && step_y;
    assign left   = step_x && hold_y;
    assign legal  = diag || up || left;

    assign is_start  = (nx == TOP_IDX) && (ny == TOP_IDX);
    assign is_origin = (nx == '0) && (ny == '0);

    assign c1_cur = pick(s1, cy);
    assign c2_cur = pick(s2, cx);

    assign load = (state == S_TRACK && accept && legal) ||
                  (state == S_LAST && out_free);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            rdy_q <= 1'b0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n == S_IDLE) || (state_n == S_TRACK);
            if (accept) begin
                cx <= nx;
                cy <= ny;
            end
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = is_start ? S_TRACK : S_ERR;
            S_TRACK: if (accept) begin
                         if (!legal)        state_n = S_ERR;
                         else if (is_origin) state_n = S_LAST;
                     end
            S_LAST:  if (out_free) state_n = S_FIN;
            S_FIN:   if (fire && out_last) state_n = S_DONE;
            S_DONE:  state_n = S_DONE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // Output decode
    always_comb begin
        done = (state == S_DONE);
        err  = (state == S_ERR);
    end

    // Entry for the coordinate being retired (or the (0,0) entry while in LAST)
    always_comb begin
        ent_c1   = '0;
        ent_c2   = '0;
        ent_op   = OP_MATCH;
        ent_last = 1'b0;
        if (state == S_LAST) begin
            ent_c1   = s1[CWIDTH-1:0];
            ent_c2   = s2[CWIDTH-1:0];
            ent_op   = (s1[CWIDTH-1:0] == s2[CWIDTH-1:0]) ? OP_MATCH : OP_MISMATCH;
            ent_last = 1'b1;
        end else if (diag) begin
            ent_c1 = c1_cur;
            ent_c2 = c2_cur;
            ent_op = (c1_cur == c2_cur) ? OP_MATCH : OP_MISMATCH;
        end else if (up) begin
            ent_c1 = c1_cur;
            ent_op = OP_GAP_S2;
        end else begin
            ent_c2 = c2_cur;
            ent_op = OP_GAP_S1;
        end
    end

    // Single-entry output register; a path error discards whatever is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_c1    <= '0;
            out_c2    <= '0;
            op_q      <= OP_MATCH;
            out_last  <= 1'b0;
        end else if (state_n == S_ERR) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_c1    <= ent_c1;
            out_c2    <= ent_c2;
            op_q      <= ent_op;
            out_last  <= ent_last;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op = op_q;

`ifdef ALN_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_match    <= '0;
            n_mismatch <= '0;
            n_indel    <= '0;
            score      <= '0;
        end else if (fire) begin
            unique case (op_q)
                OP_MATCH: begin
                    if (n_match != '1) n_match <= n_match + 1'b1;
                    score <= score + SWIDTH'(MATCH);
                end
                OP_MISMATCH: begin
                    if (n_mismatch != '1) n_mismatch <= n_mismatch + 1'b1;
                    score <= score + SWIDTH'(MISMATCH);
                end
                default: begin
                    if (n_indel != '1) n_indel <= n_indel + 1'b1;
                    score <= score + SWIDTH'(INDEL);
                end
            endcase
        end
    end
`else
    assign n_match    = '0;
    assign n_mismatch = '0;
    assign n_indel    = '0;
    assign score      = '0;
`endif

endmodule

// File: tb/tb_trace_decoder.sv
// Scoreboard bench for trace_decoder: expected entries are queued as words are driven
// and popped when the DUT hands an entry over.
module tb_trace_decoder;

    localparam int LENGTH = 4;
    localparam int CWIDTH = 2;
    localparam int CL     = 8;
    localparam int SW     = 16;
`ifdef ALN_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [LENGTH*CWIDTH-1:0] s1, s2;
    logic                     in_valid;
    logic                     in_ready;
    logic [2*CL-1:0]          in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CWIDTH-1:0]        out_c1, out_c2;
    logic [1:0]               out_op;
    logic                     out_last;
    logic                     done, err;
    logic [CL:0]              n_match, n_mismatch, n_indel;
    logic signed [SW-1:0]     score;

    trace_decoder #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .CORD_LENGTH(CL), .SWIDTH(SW),
        .MATCH(1), .INDEL(-1), .MISMATCH(-1)
    ) dut (
        .clk(clk), .reset(reset), .s1(s1), .s2(s2),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c1(out_c1), .out_c2(out_c2), .out_op(out_op), .out_last(out_last),
        .done(done), .err(err),
        .n_match(n_match), .n_mismatch(n_mismatch), .n_indel(n_indel),
        .score(score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] op;
        logic       last;
    } entry_t;

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     m_match, m_mis, m_indel, m_score;
    int     trace_x[$], trace_y[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [1:0] ch(input logic [7:0] str, input int idx);
        return str[idx*2 +: 2];
    endfunction

    task automatic push_entry(input entry_t e);
        exp_q.push_back(e);
        case (e.op)
            2'b00:   begin m_match++; m_score += 1; end
            2'b01:   begin m_mis++;   m_score -= 1; end
            default: begin m_indel++; m_score -= 1; end
        endcase
    endtask

    task automatic push_step(input int cx, input int cy, input int nx, input int ny);
        entry_t e;
        e.last = 1'b0;
        e.c1   = ch(s1, cy);
        e.c2   = ch(s2, cx);
        if (cx - nx == 1 && cy - ny == 1) e.op = (e.c1 == e.c2) ? 2'b00 : 2'b01;
        else if (cx == nx) begin e.op = 2'b10; e.c2 = 2'b00; end
        else begin e.op = 2'b11; e.c1 = 2'b00; end
        push_entry(e);
    endtask

    task automatic push_last();
        entry_t e;
        e.c1   = ch(s1, 0);
        e.c2   = ch(s2, 0);
        e.op   = (e.c1 == e.c2) ? 2'b00 : 2'b01;
        e.last = 1'b1;
        push_entry(e);
    endtask

    // Hold a word on the bus until accepted; returns 1 ns after the accepting edge.
    task automatic send(input int x, input int y);
        int n;
        in_data  = {8'(y), 8'(x)};
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_match = 0; m_mis = 0; m_indel = 0; m_score = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_and_check(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_err"}, {31'd0, err}, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_n_match"}, n_match, STATS_ON ? m_match : 0);
        check({tag, "_n_mismatch"}, n_mismatch, STATS_ON ? m_mis : 0);
        check({tag, "_n_indel"}, n_indel, STATS_ON ? m_indel : 0);
        check({tag, "_score"}, score, STATS_ON ? m_score : 0);
    endtask

    task automatic run_trace(input string tag);
        send(trace_x[0], trace_y[0]);
        for (int i = 1; i < trace_x.size(); i++) begin
            push_step(trace_x[i-1], trace_y[i-1], trace_x[i], trace_y[i]);
            if (trace_x[i] == 0 && trace_y[i] == 0) push_last();
            send(trace_x[i], trace_y[i]);
        end
        wait_done_and_check(tag);
    endtask

    task automatic load_diag_trace();
        trace_x = '{3, 2, 1, 0};
        trace_y = '{3, 2, 1, 0};
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", exp_q.size(), 1);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("out_c1", out_c1, e.c1);
                check("out_c2", out_c2, e.c2);
                check("out_op", out_op, e.op);
                check("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t held;
        s1        = {2'd3, 2'd2, 2'd1, 2'd0};   // ACGT
        s2        = {2'd3, 2'd2, 2'd1, 2'd0};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_op", out_op, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_score", score, 0);
        @(negedge clk);
        reset = 1'b0;
        m_match = 0; m_mis = 0; m_indel = 0; m_score = 0;
        @(posedge clk);
        #1 check("first_in_ready", {31'd0, in_ready}, 1);

        // Identical strings
        out_ready = 1'b1;
        load_diag_trace();
        run_trace("ident");
        check("ident_score_model", m_score, 4);

        // Gap path
        do_reset();
        s2 = {2'd0, 2'd2, 2'd1, 2'd0};           // ACGA
        trace_x = '{3, 3, 2, 1, 0};
        trace_y = '{3, 2, 1, 0, 0};
        run_trace("gap");
        check("gap_score_model", m_score, -3);

        // Backpressure on the first entry
        do_reset();
        s2 = {2'd3, 2'd2, 2'd1, 2'd0};
        out_ready = 1'b0;
        send(3, 3);
        push_step(3, 3, 2, 2);
        send(2, 2);
        held = exp_q[0];
        push_step(2, 2, 1, 1);
        in_data  = {8'd1, 8'd1};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 1);
            check("bp_c1", out_c1, held.c1);
            check("bp_op", out_op, held.op);
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(1, 1);
        push_step(1, 1, 0, 0);
        push_last();
        send(0, 0);
        wait_done_and_check("bp");

        // Bad start
        do_reset();
        send(2, 3);
        check("bs_err", {31'd0, err}, 1);
        check("bs_out_valid", {31'd0, out_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bs_in_ready", {31'd0, in_ready}, 0);
        end

        // Bad step
        do_reset();
        send(3, 3);
        send(1, 1);
        check("bstep_err", {31'd0, err}, 1);
        check("bstep_out_valid", {31'd0, out_valid}, 0);
        check("bstep_n_match", n_match, 0);
        check("bstep_score", score, 0);

        // Reset mid-trace, then a fresh full trace
        do_reset();
        send(3, 3);
        push_step(3, 3, 2, 2);
        send(2, 2);
        #1 reset = 1'b1;
        #1;
        check("mid_out_valid", {31'd0, out_valid}, 0);
        check("mid_in_ready", {31'd0, in_ready}, 0);
        check("mid_out_c1", out_c1, 0);
        check("mid_out_c2", out_c2, 0);
        check("mid_out_last", {31'd0, out_last}, 0);
        check("mid_err", {31'd0, err}, 0);
        do_reset();
        load_diag_trace();
        run_trace("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_decoder.md
# trace_decoder

Consumes the traceback coordinate stream produced by the scoring grid and turns it into aligned character pairs with edit operations, one per handshake. Each coordinate word is `{y, x}` and the words arrive in grid order, from (LENGTH-1, LENGTH-1) down to (0,0). The block checks that every step is a legal single move and flags any broken path. It sits directly downstream of the grid's traceback writer and upstream of the alignment formatter/host readout. Output order is end-of-string first, the same order as the trace.

## Interface
- LENGTH, 10: characters per string; must be ≥ 2.
- CWIDTH, 2: bits per character.
- CORD_LENGTH, 8: bits per coordinate.
- SWIDTH, 16: bits of the signed score.
- MATCH, 1: signed match weight.
- INDEL, -1: signed gap weight.
- MISMATCH, -1: signed mismatch weight.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- s1  in  LENGTH*CWIDTH  string 1; character j is at s1[j*CWIDTH +: CWIDTH] and is indexed by y.
- s2  in  LENGTH*CWIDTH  string 2; character k is indexed by x.
- in_valid  in  1  coordinate word valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- in_data  in  2*CORD_LENGTH  x = [CORD_LENGTH-1:0], y = [2*CORD_LENGTH-1:CORD_LENGTH].
- out_valid  out  1  aligned pair valid.
- out_ready  in  1  consumer accepts.
- out_c1, out_c2  out  CWIDTH  characters; driven to 0 when the side is a gap.
- out_op  out  2  00 match, 01 mismatch, 10 gap in s2 (top move), 11 gap in s1 (left move).
- out_last  out  1  marks the (0,0) entry.
- done  out  1  sticky after the last handshake.
- err  out  1  sticky path error.
- n_match, n_mismatch, n_indel  out  CORD_LENGTH+1  operation counters.
- score  out  SWIDTH signed  recomputed alignment score.

## Operation
- States:
  - IDLE: waiting for the first word.
  - TRACK: holds the current coordinate (cx, cy).
  - LAST: emits the (0,0) entry.
  - FIN: waits for the last handshake.
  - DONE: finished.
  - ERR: path error.
- IDLE: the first accepted word must be (LENGTH-1, LENGTH-1).
  - If so, it is stored as current, the block moves to TRACK, and no output is produced.
  - Otherwise the block moves to ERR.
- TRACK, on accepting a new word (nx, ny), the delta (cx-nx, cy-ny) selects the entry for the current coordinate:
  - (1,1): s1[cy] vs s2[cx]; op 00 if equal, else 01.
  - (0,1): s1[cy] vs gap; op 10.
  - (1,0): gap vs s2[cx]; op 11.
  - Any other delta, including a repeated coordinate or an increasing coordinate: move to ERR.
- After a legal step, (nx, ny) becomes current. If it is (0,0), move to LAST.
- LAST: when the output register is free, load the diagonal entry s1[0]/s2[0] with out_last=1, then move to FIN.
- FIN: on the out_last handshake, move to DONE.
- DONE and ERR: in_ready=0 and out_valid=0. Only reset leaves these states.
- Entering ERR drops any pending output and sets err.
- Single-entry output register: the entry and its flags hold stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0, out_valid=0, out_c1=out_c2=0, out_op=0, out_last=0, done=0, err=0, all counters and score 0. State is IDLE.
- in_ready = (IDLE or TRACK) && (!out_valid || out_ready), registered from next-state, so it is 1 in the first cycle after reset releases.
- Latency: a word accepted at edge t makes its entry visible with out_valid=1 after edge t.
- Full throughput of one word per cycle is sustained when out_ready=1.
- Output fire and input accept in the same cycle: the register reloads with no bubble.
- LAST entry: follows the (0,0) accept by one cycle when out_ready=1.
- done rises the cycle after the out_last handshake.
- err rises the cycle after the offending accept.
- Reset asserted mid-trace: every output is cleared immediately (asynchronously); a partial trace is discarded.

## Configuration
- ALN_STATS_EN defined: counters and score update on every output handshake.
  - Score adds MATCH, MISMATCH or INDEL per op, with SWIDTH-bit signed wrapping arithmetic.
  - Counters saturate at all-ones.
  - The final values are stable once done=1.
- ALN_STATS_EN undefined: n_match, n_mismatch, n_indel and score are tied to 0. No counter logic is built; the ports remain.

## Test plan
All scenarios use LENGTH=4 and A=0, C=1, G=2, T=3.
- Identical strings: s1=s2="ACGT", words (3,3),(2,2),(1,1),(0,0) with out_ready=1 → 4 entries, all op 00, out_last on the 4th, done set; with ALN_STATS_EN, score=4 and n_match=4.
- Gap path: s1="ACGT", s2="ACGA", words (3,3),(3,2),(2,1),(1,0),(0,0) → ops 10, 01, 01, 11, 00 in that order; with ALN_STATS_EN, score=-3.
- Backpressure: the identical-strings case with out_ready=0 for 5 cycles after the first entry → the entry holds stable, in_ready=0, and there is no loss or duplication after release.
- Bad start: first word (2,3) → err=1 one cycle later, no output, in_ready stays 0.
- Bad step: words (3,3),(1,1) → err=1, out_valid=0, counters unchanged.
- Reset mid-trace: assert reset after the 2nd word → all outputs 0 immediately; a fresh full trace then completes with the correct result.
